// File: rtl/bcd2bin.sv
// Packed BCD to unsigned binary converter using reverse double dabble, one bit per clock.
// Define BCD2BIN_SAT_EN to clamp bin to all ones whenever the value overflows OUT_W bits.
module bcd2bin #(
    parameter int DIGITS = 3,
    parameter int OUT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [OUT_W-1:0]      bin,
    output logic                  ovf,
    output logic                  err
);
    localparam int BW = 4 * DIGITS;
    localparam int WW = BW + OUT_W;
    localparam int CW = $clog2(OUT_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ERRW, S_FIN} state_t;

    state_t          r_state;
    logic [WW-1:0]   r_work;
    logic [CW-1:0]   r_cnt;
    logic            r_err_flag;

    logic [WW-1:0]     w_shr;
    logic [WW-1:0]     w_adj;
    logic [DIGITS-1:0] w_bad;
    logic              w_ovf;
    logic [OUT_W-1:0]  w_bin;

    assign w_shr = r_work >> 1;
    assign w_adj[OUT_W-1:0] = w_shr[OUT_W-1:0];

    // Each BCD nibble is corrected independently after the shift: >= 8 means it borrowed a ten.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_adj[OUT_W+4*gi +: 4] = (w_shr[OUT_W+4*gi +: 4] >= 4'd8)
                                          ? w_shr[OUT_W+4*gi +: 4] - 4'd3
                                          : w_shr[OUT_W+4*gi +: 4];
            assign w_bad[gi] = (bcd_in[4*gi +: 4] > 4'd9);
        end
    endgenerate

    // Whatever remains in the BCD field after OUT_W shifts is value >> OUT_W.
    assign w_ovf = |r_work[WW-1:OUT_W];
`ifdef BCD2BIN_SAT_EN
    assign w_bin = w_ovf ? {OUT_W{1'b1}} : r_work[OUT_W-1:0];
`else
    assign w_bin = r_work[OUT_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_work     <= '0;
            r_cnt      <= '0;
            r_err_flag <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bin        <= '0;
            ovf        <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work     <= {bcd_in, {OUT_W{1'b0}}};
                        r_cnt      <= '0;
                        r_err_flag <= |w_bad;
                        busy       <= 1'b1;
                        r_state    <= (|w_bad) ? S_ERRW : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_work <= w_adj;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == CW'(OUT_W - 1)) begin
                        r_state <= S_FIN;
                    end
                end
                // Invalid digit: one spare cycle so the error result lands at a fixed latency.
                S_ERRW: begin
                    r_state <= S_FIN;
                end
                S_FIN: begin
                    if (r_err_flag) begin
                        bin <= '0;
                        ovf <= 1'b0;
                        err <= 1'b1;
                    end else begin
                        bin <= w_bin;
                        ovf <= w_ovf;
                        err <= 1'b0;
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd2bin.sv
// Directed-vector bench for bcd2bin (DIGITS=3, OUT_W=8) with immediate-assertion checks.
module tb_bcd2bin;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] bcd_in = '0;
    logic        busy, done, ovf, err;
    logic [7:0]  bin;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int k_cyc  = 0;

    bcd2bin #(.DIGITS(3), .OUT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .bin(bin), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef BCD2BIN_SAT_EN
    localparam logic [7:0] EXP_256 = 8'hFF;
    localparam logic [7:0] EXP_999 = 8'hFF;
`else
    localparam logic [7:0] EXP_256 = 8'h00;
    localparam logic [7:0] EXP_999 = 8'hE7;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after an edge; start is sampled on the following edge k.
    task automatic launch(input logic [11:0] v);
        start  = 1'b1;
        bcd_in = v;
        @(posedge clk);
        k_cyc = cyc + 1;
        #1;
        start  = 1'b0;
        bcd_in = 12'hBAD;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        check("done_after_start", {31'b0, done}, 32'd0);
    endtask

    task automatic wait_done(input string tag, input int exp_lat,
                             input logic [7:0] eb, input logic eo, input logic ee);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done !== 1'b1) check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        end
        check({tag, "_latency"}, cyc - k_cyc, exp_lat);
        check({tag, "_bin"}, {24'b0, bin}, {24'b0, eb});
        check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
        check({tag, "_err"}, {31'b0, err}, {31'b0, ee});
        check({tag, "_busy_low"}, {31'b0, busy}, 32'd0);
        $display("conv %s: bin=%02h ovf=%0b err=%0b latency=%0d", tag, bin, ovf, err, cyc - k_cyc);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_bin",  {24'b0, bin},  32'd0);
        check("rst_ovf",  {31'b0, ovf},  32'd0);
        check("rst_err",  {31'b0, err},  32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: largest in-range value, then the result must hold and done must drop.
        launch(12'h255);
        wait_done("t1_255", 9, 8'hFF, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("t1_done_pulse", {31'b0, done}, 32'd0);
        repeat (3) @(posedge clk); #1;
        check("t1_hold_bin", {24'b0, bin}, 32'h0FF);

        // 2: first overflowing value.
        launch(12'h256);
        wait_done("t2_256", 9, EXP_256, 1'b1, 1'b0);

        // 3: back-to-back, second start issued in the done cycle.
        @(posedge clk); #1;
        launch(12'h000);
        wait_done("t3_000", 9, 8'h00, 1'b0, 1'b0);
        launch(12'h999);
        wait_done("t3_999", 9, EXP_999, 1'b1, 1'b0);

        // 4: invalid digit, then a clean conversion clears err.
        @(posedge clk); #1;
        launch(12'h1A5);
        wait_done("t4_1A5", 2, 8'h00, 1'b0, 1'b1);
        launch(12'h042);
        wait_done("t4_042", 9, 8'h2A, 1'b0, 1'b0);

        // 5: a start three clocks into a conversion is ignored.
        @(posedge clk); #1;
        launch(12'h128);
        @(posedge clk); #1;
        start = 1'b1; bcd_in = 12'h007;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t5_128", 9, 8'h80, 1'b0, 1'b0);
        begin
            int extra;
            extra = 0;
            repeat (12) begin
                @(posedge clk); #1;
                if (done === 1'b1) extra++;
            end
            check("t5_single_done", extra, 0);
        end

        // 6: reset sampled at iteration 4 aborts; then a normal conversion follows.
        launch(12'h200);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_rst_busy", {31'b0, busy}, 32'd0);
        check("t6_rst_bin",  {24'b0, bin},  32'd0);
        check("t6_rst_ovf",  {31'b0, ovf},  32'd0);
        check("t6_rst_err",  {31'b0, err},  32'd0);
        begin
            int seen;
            seen = 0;
            repeat (10) begin
                @(posedge clk); #1;
                if (done === 1'b1) seen++;
            end
            check("t6_no_done", seen, 0);
        end
        launch(12'h017);
        wait_done("t6_017", 9, 8'h11, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
